mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand and HI/LO width (even, at least 8).
REQ-002 The block SHALL have parameter CNT_W, default $clog2(WIDTH)+1, iteration counter width.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have port start  input  1  operation request, sampled on a rising edge of clk.
REQ-006 The block SHALL have port op  input  3  operation code: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-007 The block SHALL have port srcA  input  WIDTH  multiplicand/dividend; MTHI/MTLO data.
REQ-008 The block SHALL have port srcB  input  WIDTH  multiplier/divisor.
REQ-009 The block SHALL have port busy  output  1  iterative operation in progress.
REQ-010 The block SHALL have port done  output  1  one-cycle pulse: HI/LO hold new result.
REQ-011 The block SHALL have port dz  output  1  last DIV/DIVU had divisor zero; sticky until next accepted DIV/DIVU.
REQ-012 The block SHALL have port hi  output  WIDTH  HI register.
REQ-013 The block SHALL have port lo  output  WIDTH  LO register.

Function
REQ-014 The FSM SHALL have three states: IDLE, CALC and FIX.
REQ-015 A start SHALL be accepted only in IDLE; start with busy=1 SHALL be ignored, with no effect on state, operands or HI/LO.
REQ-016 The accepting edge SHALL latch the operands and op.
REQ-017 For MULT/DIV, the accepting edge SHALL store the operand magnitudes and result signs; MULTU/DIVU SHALL use the operands unsigned.
REQ-018 For MULT/MULTU/DIV/DIVU with a nonzero divisor, the accepting edge (k) SHALL move the FSM to CALC, with busy=1 from k.
REQ-019 CALC SHALL run exactly WIDTH cycles, one radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide.
REQ-020 After CALC, the FSM SHALL enter FIX for 1 cycle to apply sign correction; at the FIX-exit edge (k+WIDTH+1) it SHALL write HI/LO, set done=1 for exactly one cycle, drop busy, and return to IDLE.
REQ-021 Multiply: {hi,lo} SHALL equal the full 2*WIDTH-bit product, signed or unsigned per op.
REQ-022 Divide: lo SHALL be the quotient truncated toward zero, and hi the remainder carrying the dividend's sign.
REQ-023 Divide of the most-negative value by -1 SHALL give lo=most-negative, hi=0, with no flag.
REQ-024 DIV/DIVU with srcB=0 SHALL NOT enter CALC: at the next edge, done=1, dz=1, HI/LO unchanged, busy never asserted.
REQ-025 An accepted DIV/DIVU with nonzero srcB SHALL clear dz at the accepting edge.
REQ-026 MTHI/MTLO in IDLE SHALL write srcA to hi/lo at the accepting edge; no busy, no done.
REQ-027 HI/LO SHALL be readable at all times and SHALL keep their old values while busy.
REQ-028 Unused op codes with start=1 SHALL be ignored.
REQ-029 The counter SHALL load WIDTH-1 on entering CALC and leave CALC on reaching zero.

Reset
REQ-030 rst=1 SHALL immediately (asynchronously) force IDLE and busy=0, done=0, dz=0, hi=0, lo=0, counter=0.
REQ-031 Reset mid-CALC or mid-FIX SHALL abort the operation with no partial write to HI/LO.
REQ-032 A start coincident with the first edge after rst deasserts SHALL be accepted normally.

Structure
REQ-033 Op-code constants, the FSM state encoding and the WIDTH default SHALL reside in shared package mdu_pkg, alongside the ALU control definitions.
REQ-034 One sub-module, mdu_step, SHALL implement the combinational single-iteration add/shift and subtract/shift; FSM, counter and registers SHALL live in mult_div_unit.

Verification
REQ-035 With WIDTH=32, MULT srcA=0xFFFFFFFF, srcB=2 SHALL give, at cycle 34 after accept, done=1, hi=0xFFFFFFFF, lo=0xFFFFFFFE; the same operands with MULTU SHALL give hi=0x00000001, lo=0xFFFFFFFE.
REQ-036 DIV srcA=0xFFFFFFF9 (-7), srcB=2 SHALL give lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU 7/2 SHALL give lo=3, hi=1.
REQ-037 With hi=0x12345678, DIVU srcB=0 SHALL give done on the next cycle, dz=1, hi unchanged, busy=0 throughout; a following DIVU 9/3 SHALL clear dz and give lo=3.
REQ-038 start=1 with MTLO 0xDEAD during busy SHALL be ignored: the original result SHALL be delivered and lo SHALL NOT equal 0xDEAD.
REQ-039 rst pulsed at CALC cycle 10 SHALL immediately give busy=0 and hi=lo=0, with no done pulse; a new MULT 3*5 SHALL then give lo=15, hi=0.
REQ-040 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0, dz=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg
// Shared definitions for the multiply/divide unit and its neighbours in the
// execute stage: HI/LO operation codes, the multiply/divide FSM state
// encoding, the default datapath width and the ALU control codes.
// No ports (package).

package mdu_pkg;

   localparam int MDU_WIDTH = 32;

   // Multiply/divide unit operation codes; 3'd6 and 3'd7 are not assigned
   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   // Multiply/divide FSM state encoding
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_FIX  = 2'd2;

   // ALU control codes used by the integer ALU next to this unit
   typedef enum logic [3:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_XOR,
      ALU_NOR,
      ALU_SLT,
      ALU_SLTU,
      ALU_SLL,
      ALU_SRL,
      ALU_SRA
   } alu_ctrl_t;

endpackage

// File: rtl/mdu_if.sv
// mdu_if
// Request/result bundle between the pipeline and the multiply/divide unit.
//   start, op, srcA, srcB : request from the pipeline (master drives)
//   busy, done, dz        : status from the unit (slave drives)
//   hi, lo                : HI/LO architectural registers (slave drives)

interface mdu_if
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH
);

   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] srcA;
   logic [WIDTH-1:0] srcB;
   logic             busy;
   logic             done;
   logic             dz;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, srcA, srcB,
      input  busy, done, dz, hi, lo
   );

   modport slave (
      input  start, op, srcA, srcB,
      output busy, done, dz, hi, lo
   );

endinterface

// File: rtl/mdu_step.sv
// mdu_step
// One radix-2 iteration of the multiply/divide datapath, purely combinational.
//   is_div  : 1 = restoring shift-subtract divide step, 0 = shift-add multiply step
//   acc     : upper half (partial product / partial remainder)
//   q       : lower half (remaining multiplier bits / dividend bits -> quotient)
//   b       : multiplicand magnitude or divisor magnitude
//   acc_nxt : next upper half
//   q_nxt   : next lower half

module mdu_step
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH
) (
   input  logic             is_div,
   input  logic [WIDTH-1:0] acc,
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] acc_nxt,
   output logic [WIDTH-1:0] q_nxt
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   // Multiply: add b when the current multiplier bit is set, then shift
   // {carry, acc, q} right by one so product bits drop into q.
   // Divide: shift the next dividend bit into the partial remainder and try
   // subtracting the divisor. The remainder stays below b, so shifted < 2*b
   // and diff[WIDTH] is exactly the borrow of the trial subtraction.
   always_comb begin
      sum     = {1'b0, acc} + (q[0] ? {1'b0, b} : {(WIDTH+1){1'b0}});
      shifted = {acc, q[WIDTH-1]};
      diff    = shifted - {1'b0, b};
      if (is_div) begin
         if (!diff[WIDTH]) begin
            acc_nxt = diff[WIDTH-1:0];
            q_nxt   = {q[WIDTH-2:0], 1'b1};
         end else begin
            acc_nxt = shifted[WIDTH-1:0];
            q_nxt   = {q[WIDTH-2:0], 1'b0};
         end
      end else begin
         acc_nxt = sum[WIDTH:1];
         q_nxt   = {sum[0], q[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit
// Iterative multiply/divide unit with HI/LO registers.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : mdu_if.slave -- start/op/srcA/srcB in; busy/done/dz/hi/lo out
// MULT/MULTU/DIV/DIVU run WIDTH iterations in CALC plus one FIX cycle for
// sign correction; divide by zero finishes immediately with dz set;
// MTHI/MTLO write HI/LO directly from IDLE.

module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input logic  clk,
   input logic  rst,
   mdu_if.slave bus
);

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] b;
   logic             is_div;
   logic             neg_lo;
   logic             neg_hi;
   logic [WIDTH-1:0] hi_r;
   logic [WIDTH-1:0] lo_r;
   logic             done_r;
   logic             dz_r;

   logic             signed_op;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH-1:0] acc_nxt;
   logic [WIDTH-1:0] q_nxt;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0] quo_fix;
   logic [WIDTH-1:0] rem_fix;

   // The datapath works on unsigned magnitudes; the sign of each operand is
   // only honoured for MULT and DIV. The magnitude of the most-negative value
   // is representable as an unsigned WIDTH-bit number, so no extra bit needed.
   always_comb begin
      signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
      a_neg     = signed_op & bus.srcA[WIDTH-1];
      b_neg     = signed_op & bus.srcB[WIDTH-1];
      a_mag     = a_neg ? -bus.srcA : bus.srcA;
      b_mag     = b_neg ? -bus.srcB : bus.srcB;
   end

   mdu_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .is_div  (is_div),
      .acc     (acc),
      .q       (q),
      .b       (b),
      .acc_nxt (acc_nxt),
      .q_nxt   (q_nxt)
   );

   // Sign correction applied in FIX. For multiply neg_lo is the product sign;
   // for divide it is the quotient sign and neg_hi the dividend sign, which
   // gives truncation toward zero and a remainder following the dividend.
   always_comb begin
      prod_fix = neg_lo ? -{acc, q} : {acc, q};
      quo_fix  = neg_lo ? -q : q;
      rem_fix  = neg_hi ? -acc : acc;
   end

   // FSM, iteration counter, operand registers and HI/LO. Requests are only
   // looked at in IDLE, so anything presented while busy has no effect.
   // HI/LO are written solely at the FIX exit, so an aborted run never
   // leaves a partial result behind.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         acc    <= '0;
         q      <= '0;
         b      <= '0;
         is_div <= 1'b0;
         neg_lo <= 1'b0;
         neg_hi <= 1'b0;
         hi_r   <= '0;
         lo_r   <= '0;
         done_r <= 1'b0;
         dz_r   <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  case (bus.op)
                     OP_MULT, OP_MULTU: begin
                        acc    <= '0;
                        q      <= b_mag;
                        b      <= a_mag;
                        is_div <= 1'b0;
                        neg_lo <= a_neg ^ b_neg;
                        neg_hi <= 1'b0;
                        cnt    <= CNT_W'(WIDTH - 1);
                        state  <= ST_CALC;
                     end
                     OP_DIV, OP_DIVU: begin
                        if (bus.srcB == '0) begin
                           done_r <= 1'b1;
                           dz_r   <= 1'b1;
                        end else begin
                           acc    <= '0;
                           q      <= a_mag;
                           b      <= b_mag;
                           is_div <= 1'b1;
                           neg_lo <= a_neg ^ b_neg;
                           neg_hi <= a_neg;
                           dz_r   <= 1'b0;
                           cnt    <= CNT_W'(WIDTH - 1);
                           state  <= ST_CALC;
                        end
                     end
                     OP_MTHI: hi_r <= bus.srcA;
                     OP_MTLO: lo_r <= bus.srcA;
                     default: ;
                  endcase
               end
            end
            ST_CALC: begin
               acc <= acc_nxt;
               q   <= q_nxt;
               if (cnt == '0) begin
                  state <= ST_FIX;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            ST_FIX: begin
               if (is_div) begin
                  hi_r <= rem_fix;
                  lo_r <= quo_fix;
               end else begin
                  hi_r <= prod_fix[2*WIDTH-1:WIDTH];
                  lo_r <= prod_fix[WIDTH-1:0];
               end
               done_r <= 1'b1;
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy = (state != ST_IDLE);
   assign bus.done = done_r;
   assign bus.dz   = dz_r;
   assign bus.hi   = hi_r;
   assign bus.lo   = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
// Self-checking bench for mult_div_unit (WIDTH=32). A reference model built
// on plain 64-bit arithmetic predicts HI/LO/dz/busy/done every cycle; directed
// vectors with hand-computed literals pin the model and the corner cases.

module tb_mult_div_unit;
   import mdu_pkg::*;

   localparam int WIDTH = 32;

   logic clk = 1'b0;
   logic rst = 1'b0;

   mdu_if #(.WIDTH(WIDTH)) bus ();

   mult_div_unit #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit compareOn = 1'b0;
   bit finished = 1'b0;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Expected {hi, lo} of a multiply: the full 64-bit product
   function automatic logic [63:0] expectMul(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa;
      longint sb;
      if (op == OP_MULT) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         return sa * sb;
      end
      return {32'b0, a} * {32'b0, b};
   endfunction

   // Expected {hi, lo} of a divide: {remainder, quotient}, C-style truncation
   function automatic logic [63:0] expectDiv(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa;
      longint sb;
      logic [63:0] qv;
      logic [63:0] rv;
      if (op == OP_DIV) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         qv = sa / sb;
         rv = sa % sb;
         return {rv[31:0], qv[31:0]};
      end
      return {a % b, a / b};
   endfunction

   // Reference model: an accepted iterative op yields its result WIDTH+1
   // edges after the accepting edge; nothing is accepted while one is pending.
   logic [31:0] mHi = '0;
   logic [31:0] mLo = '0;
   logic        mDz = 1'b0;
   logic        mDone = 1'b0;
   logic [63:0] pRes = '0;
   int          pend = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mHi   <= '0;
         mLo   <= '0;
         mDz   <= 1'b0;
         mDone <= 1'b0;
         pend  <= 0;
      end else begin
         mDone <= 1'b0;
         if (pend > 0) begin
            pend <= pend - 1;
            if (pend == 1) begin
               mHi   <= pRes[63:32];
               mLo   <= pRes[31:0];
               mDone <= 1'b1;
            end
         end else if (bus.start) begin
            case (bus.op)
               OP_MULT, OP_MULTU: begin
                  pRes <= expectMul(bus.op, bus.srcA, bus.srcB);
                  pend <= WIDTH + 1;
               end
               OP_DIV, OP_DIVU: begin
                  if (bus.srcB == '0) begin
                     mDone <= 1'b1;
                     mDz   <= 1'b1;
                  end else begin
                     pRes <= expectDiv(bus.op, bus.srcA, bus.srcB);
                     mDz  <= 1'b0;
                     pend <= WIDTH + 1;
                  end
               end
               OP_MTHI: mHi <= bus.srcA;
               OP_MTLO: mLo <= bus.srcA;
               default: ;
            endcase
         end
      end
   end

   // Every-cycle comparison against the model, on the falling edge
   always @(negedge clk) begin
      if (compareOn && !finished) begin
         checkOutput("cyc_busy", bus.busy, (pend > 0));
         checkOutput("cyc_done", bus.done, mDone);
         checkOutput("cyc_dz", bus.dz, mDz);
         checkOutput("cyc_hi", bus.hi, mHi);
         checkOutput("cyc_lo", bus.lo, mLo);
      end
   end

   // Present a request for exactly one rising edge; returns 2 units after it
   task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.start = 1'b1;
      bus.op    = op;
      bus.srcA  = a;
      bus.srcB  = b;
      @(posedge clk);
      #2;
      bus.start = 1'b0;
   endtask

   // Count falling edges until done; bounded, expiry is a failure
   task automatic waitDone(output int lat);
      lat = 0;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            lat = i;
            break;
         end
      end
      if (lat == 0) checkOutput("done_timeout", bus.done, 1'b1);
      @(posedge clk);
      #2;
   endtask

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
   } vec_t;

   vec_t vecs[6] = '{
      '{OP_MULT,  32'h12345678, 32'h9ABCDEF0},
      '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF},
      '{OP_DIV,   32'h80000000, 32'h00000007},
      '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010},
      '{OP_DIV,   32'h00000005, 32'hFFFFFFFD},
      '{OP_MULT,  32'h7FFFFFFF, 32'h80000000}
   };

   initial begin
      int lat;
      bus.start = 1'b0;
      bus.op    = '0;
      bus.srcA  = '0;
      bus.srcB  = '0;

      #1 rst = 1'b1;
      #1;
      checkOutput("rst_busy", bus.busy, 1'b0);
      checkOutput("rst_done", bus.done, 1'b0);
      checkOutput("rst_dz", bus.dz, 1'b0);
      checkOutput("rst_hi", bus.hi, 32'h0);
      checkOutput("rst_lo", bus.lo, 32'h0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      compareOn = 1'b1;

      $display("[TB] signed/unsigned multiply of 0xFFFFFFFF by 2");
      applyStimulus(OP_MULT, 32'hFFFFFFFF, 32'h2);
      checkOutput("mult_busy_at_accept", bus.busy, 1'b1);
      waitDone(lat);
      checkOutput("mult_latency", lat, 34);
      checkOutput("mult_hi", bus.hi, 32'hFFFFFFFF);
      checkOutput("mult_lo", bus.lo, 32'hFFFFFFFE);
      applyStimulus(OP_MULTU, 32'hFFFFFFFF, 32'h2);
      waitDone(lat);
      checkOutput("multu_hi", bus.hi, 32'h00000001);
      checkOutput("multu_lo", bus.lo, 32'hFFFFFFFE);

      $display("[TB] signed and unsigned divide");
      applyStimulus(OP_DIV, 32'hFFFFFFF9, 32'h2);
      waitDone(lat);
      checkOutput("div_latency", lat, 34);
      checkOutput("div_lo", bus.lo, 32'hFFFFFFFD);
      checkOutput("div_hi", bus.hi, 32'hFFFFFFFF);
      applyStimulus(OP_DIVU, 32'h7, 32'h2);
      waitDone(lat);
      checkOutput("divu_lo", bus.lo, 32'h3);
      checkOutput("divu_hi", bus.hi, 32'h1);

      $display("[TB] vector table against the model");
      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
         waitDone(lat);
      end

      $display("[TB] most-negative divided by -1");
      applyStimulus(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
      waitDone(lat);
      checkOutput("minneg_lo", bus.lo, 32'h80000000);
      checkOutput("minneg_hi", bus.hi, 32'h0);
      checkOutput("minneg_dz", bus.dz, 1'b0);

      $display("[TB] divide by zero and dz clearing");
      applyStimulus(OP_MTHI, 32'h12345678, 32'h0);
      checkOutput("mthi_hi", bus.hi, 32'h12345678);
      checkOutput("mthi_done", bus.done, 1'b0);
      applyStimulus(OP_DIVU, 32'h5, 32'h0);
      checkOutput("dz_done", bus.done, 1'b1);
      checkOutput("dz_flag", bus.dz, 1'b1);
      checkOutput("dz_busy", bus.busy, 1'b0);
      checkOutput("dz_hi", bus.hi, 32'h12345678);
      applyStimulus(OP_DIVU, 32'h9, 32'h3);
      checkOutput("dz_cleared", bus.dz, 1'b0);
      waitDone(lat);
      checkOutput("div93_lo", bus.lo, 32'h3);
      checkOutput("div93_hi", bus.hi, 32'h0);

      $display("[TB] start while busy is ignored");
      applyStimulus(OP_DIVU, 32'd100, 32'd7);
      repeat (5) @(posedge clk);
      #2;
      bus.start = 1'b1;
      bus.op    = OP_MTLO;
      bus.srcA  = 32'hDEAD;
      repeat (3) @(posedge clk);
      #2;
      bus.start = 1'b0;
      waitDone(lat);
      checkOutput("ignore_lo", bus.lo, 32'd14);
      checkOutput("ignore_hi", bus.hi, 32'd2);
      checkOutput("ignore_not_dead", (bus.lo != 32'hDEAD), 1'b1);

      $display("[TB] unused op code");
      applyStimulus(3'd6, 32'hAAAA5555, 32'h1);
      checkOutput("unused_busy", bus.busy, 1'b0);
      checkOutput("unused_lo", bus.lo, 32'd14);

      $display("[TB] reset in the middle of CALC");
      applyStimulus(OP_MULT, 32'h1234, 32'h10);
      repeat (10) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("abort_busy", bus.busy, 1'b0);
      checkOutput("abort_done", bus.done, 1'b0);
      checkOutput("abort_hi", bus.hi, 32'h0);
      checkOutput("abort_lo", bus.lo, 32'h0);
      #3;
      rst = 1'b0;
      applyStimulus(OP_MULT, 32'd3, 32'd5);
      waitDone(lat);
      checkOutput("post_rst_latency", lat, 34);
      checkOutput("post_rst_lo", bus.lo, 32'd15);
      checkOutput("post_rst_hi", bus.hi, 32'd0);

      repeat (3) @(posedge clk);
      finished = 1'b1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      if (!finished) begin
         finished = 1'b1;
         checkOutput("watchdog", 1'b1, 1'b0);
         $display("Simulation finished: %0d checks, %0d errors", checks, errors);
         $finish;
      end
   end

endmodule
